// File: rtl/fetch_request_unit_pkg.sv
// Shared types and constants for the fetch/request sequencer.
// Covers FSM state, jump-select encodings and the PC step size.
package fetch_request_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DATA  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef logic [1:0] jumpsel_t;

  localparam jumpsel_t JS_SEQ = 2'b00;
  localparam jumpsel_t JS_J   = 2'b01;
  localparam jumpsel_t JS_JR  = 2'b10;

  localparam logic [31:0] PC_STEP = 32'd4;

  // The branch offset counts words, so shift it to a byte offset after sign-extending.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_request_unit_if.sv
// Decoded-control inputs, memory handshake and PC outputs of the fetch/request unit.
interface fetch_request_unit_if;
  import fetch_request_unit_pkg::*;

  logic        ihit;
  logic        dhit;
  logic        PCSrc;
  logic        BNE;
  logic        zero;
  jumpsel_t    JumpSel;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic [31:0] jr_addr;
  logic        halt;
  logic        dREN;
  logic        dWEN;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imemREN;
  logic        dmemREN;
  logic        dmemWEN;
  logic        commit;
  logic        halted;

  modport fru (
    input  ihit, dhit, PCSrc, BNE, zero, JumpSel, imm, jaddr, jr_addr, halt, dREN, dWEN,
    output pc, pc_plus4, imemREN, dmemREN, dmemWEN, commit, halted
  );

  modport tb (
    output ihit, dhit, PCSrc, BNE, zero, JumpSel, imm, jaddr, jr_addr, halt, dREN, dWEN,
    input  pc, pc_plus4, imemREN, dmemREN, dmemWEN, commit, halted
  );

endinterface

// File: rtl/fetch_request_unit_next_pc.sv
// Purely combinational next-PC selection: sequential, branch, J/JAL and JR targets.
module fetch_request_unit_next_pc
  import fetch_request_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        PCSrc,
  input  logic        BNE,
  input  logic        zero,
  input  jumpsel_t    JumpSel,
  input  logic [15:0] imm,
  input  logic [25:0] jaddr,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic taken;
  logic [31:0] br_target;

  assign pc_plus4  = pc + PC_STEP;
  assign taken     = PCSrc & (zero ^ BNE);
  assign br_target = pc_plus4 + branch_offset(imm);

  always_comb begin
    next_pc = pc_plus4;
    case (JumpSel)
      JS_SEQ:  next_pc = taken ? br_target : pc_plus4;
      JS_J:    next_pc = {pc_plus4[31:28], jaddr, 2'b00};
      // Mask the low bits so a misaligned register value cannot misalign the PC.
      JS_JR:   next_pc = jr_addr & ~32'h3;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_request_unit.sv
// PC register and fetch -> optional data access -> PC update sequencer.
// commit fires once per retired instruction and gates the register-file write.
module fetch_request_unit
  import fetch_request_unit_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input logic             CLK,
  input logic             nRST,
  fetch_request_unit_if.fru bus
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg;
  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;
  logic         dren_reg, dwen_reg;
  logic         commit;
  logic         data_start;
  logic         data_done;

  fetch_request_unit_next_pc u_next_pc (
    .pc       (pc_reg),
    .PCSrc    (bus.PCSrc),
    .BNE      (bus.BNE),
    .zero     (bus.zero),
    .JumpSel  (bus.JumpSel),
    .imm      (bus.imm),
    .jaddr    (bus.jaddr),
    .jr_addr  (bus.jr_addr),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  // halt wins over a data access decoded in the same instruction.
  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    data_start = 1'b0;
    data_done  = 1'b0;
    case (state_reg)
      FETCH: begin
        if (bus.ihit) begin
          if (bus.halt) begin
            state_next = HALT;
          end else if (bus.dREN | bus.dWEN) begin
            state_next = DATA;
            data_start = 1'b1;
          end else begin
            commit = 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.dhit) begin
          state_next = FETCH;
          commit     = 1'b1;
          data_done  = 1'b1;
        end
      end
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= FETCH;
      pc_reg    <= PC_INIT;
      dren_reg  <= 1'b0;
      dwen_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (commit) begin
        pc_reg <= next_pc;
      end
      if (data_start) begin
        dren_reg <= bus.dREN;
        dwen_reg <= bus.dWEN;
      end else if (data_done) begin
        dren_reg <= 1'b0;
        dwen_reg <= 1'b0;
      end
    end
  end

  assign bus.pc       = pc_reg;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.imemREN  = (state_reg == FETCH);
  assign bus.dmemREN  = dren_reg;
  assign bus.dmemWEN  = dwen_reg;
  assign bus.commit   = commit;
  assign bus.halted   = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_request_unit.sv
// Directed bench for fetch_request_unit: an instruction-level model checked every cycle,
// plus hand-computed PC and handshake expectations at key points.
module tb_fetch_request_unit;

  logic CLK  = 1'b0;
  logic nRST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fetch_request_unit_if bus ();

  fetch_request_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: where the PC goes and whether a data access is in flight.
  logic [31:0] m_pc     = 32'h0;
  logic        m_busy   = 1'b0;
  logic        m_rd     = 1'b0;
  logic        m_wr     = 1'b0;
  logic        m_halted = 1'b0;

  function automatic logic [31:0] target(input logic [31:0] cur);
    logic [31:0] p4;
    int          off;
    p4  = cur + 32'd4;
    off = int'($signed(bus.imm)) * 4;
    case (bus.JumpSel)
      2'b00:   return (bus.PCSrc && (bus.zero != bus.BNE)) ? p4 + 32'(off) : p4;
      2'b01:   return (p4 & 32'hF000_0000) | (32'(bus.jaddr) * 32'd4);
      2'b10:   return (bus.jr_addr / 32'd4) * 32'd4;
      default: return p4;
    endcase
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_pc <= 32'h0; m_busy <= 1'b0; m_rd <= 1'b0; m_wr <= 1'b0; m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (m_busy) begin
        if (bus.dhit) begin
          m_pc <= target(m_pc); m_busy <= 1'b0; m_rd <= 1'b0; m_wr <= 1'b0;
        end
      end else if (bus.ihit) begin
        if (bus.halt) m_halted <= 1'b1;
        else if (bus.dREN || bus.dWEN) begin
          m_busy <= 1'b1; m_rd <= bus.dREN; m_wr <= bus.dWEN;
        end else m_pc <= target(m_pc);
      end
    end
  end

  always @(negedge CLK) begin
    logic exp_commit;
    if (m_halted)    exp_commit = 1'b0;
    else if (m_busy) exp_commit = bus.dhit;
    else             exp_commit = bus.ihit && !bus.halt && !(bus.dREN || bus.dWEN);
    check("cyc_pc",       bus.pc,       m_pc);
    check("cyc_pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    check("cyc_imemREN",  32'(bus.imemREN), 32'(!m_halted && !m_busy));
    check("cyc_dmemREN",  32'(bus.dmemREN), 32'(m_rd));
    check("cyc_dmemWEN",  32'(bus.dmemWEN), 32'(m_wr));
    check("cyc_commit",   32'(bus.commit),  32'(exp_commit));
    check("cyc_halted",   32'(bus.halted),  32'(m_halted));
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic jr_to(input logic [31:0] a);
    bus.JumpSel = 2'b10; bus.jr_addr = a; bus.ihit = 1'b1;
    cyc();
    bus.ihit = 1'b0; bus.JumpSel = 2'b00;
  endtask

  initial begin
    bus.ihit = 0; bus.dhit = 0; bus.PCSrc = 0; bus.BNE = 0; bus.zero = 0;
    bus.JumpSel = 2'b00; bus.imm = 16'h0; bus.jaddr = 26'h0; bus.jr_addr = 32'h0;
    bus.halt = 0; bus.dREN = 0; bus.dWEN = 0;
    #1 nRST = 1'b0;
    cyc(); cyc();
    nRST = 1'b1;
    cyc();
    check("reset_pc", bus.pc, 32'h0);
    check("reset_imemREN", 32'(bus.imemREN), 32'd1);
    check("reset_halted", 32'(bus.halted), 32'd0);
    $display("reset released: pc=%h", bus.pc);

    // Sequential step and hold
    jr_to(32'h40);
    check("jr_0x40", bus.pc, 32'h40);
    bus.ihit = 1'b1; #1;
    check("seq_commit", 32'(bus.commit), 32'd1);
    cyc();
    bus.ihit = 1'b0;
    check("seq_pc", bus.pc, 32'h44);
    cyc(); cyc();
    check("hold_pc", bus.pc, 32'h44);
    check("hold_commit", 32'(bus.commit), 32'd0);
    $display("sequential: pc=%h", bus.pc);

    // Branches from 0x100 with offset -2 words
    jr_to(32'h100);
    bus.PCSrc = 1; bus.BNE = 0; bus.zero = 1; bus.imm = 16'hFFFE; bus.ihit = 1; cyc();
    check("beq_taken", bus.pc, 32'hFC);
    $display("beq taken: pc=%h", bus.pc);
    jr_to(32'h100);
    bus.PCSrc = 1; bus.zero = 0; bus.ihit = 1; cyc();
    check("beq_not_taken", bus.pc, 32'h104);
    $display("beq not taken: pc=%h", bus.pc);
    jr_to(32'h100);
    bus.PCSrc = 1; bus.BNE = 1; bus.zero = 0; bus.ihit = 1; cyc();
    check("bne_taken", bus.pc, 32'hFC);
    $display("bne taken: pc=%h", bus.pc);
    bus.PCSrc = 0; bus.BNE = 0; bus.imm = 16'h0; bus.ihit = 0;

    // Jumps and wrap
    jr_to(32'h1000_0000);
    bus.JumpSel = 2'b01; bus.jaddr = 26'h0000040; bus.ihit = 1; cyc();
    check("j_target", bus.pc, 32'h1000_0100);
    $display("j: pc=%h", bus.pc);
    jr_to(32'h2003);
    check("jr_align", bus.pc, 32'h2000);
    $display("jr: pc=%h", bus.pc);
    jr_to(32'hFFFF_FFFC);
    bus.ihit = 1; cyc(); bus.ihit = 0;
    check("seq_wrap", bus.pc, 32'h0);
    $display("wrap: pc=%h", bus.pc);

    // Load handshake; ihit left high through DATA must be ignored
    bus.dREN = 1; bus.ihit = 1; cyc();
    check("ld_dmemREN", 32'(bus.dmemREN), 32'd1);
    check("ld_imemREN", 32'(bus.imemREN), 32'd0);
    check("ld_pc", bus.pc, 32'h0);
    cyc(); cyc(); cyc();
    bus.ihit = 0;
    check("ld_held", 32'(bus.dmemREN), 32'd1);
    bus.dhit = 1; #1;
    check("ld_commit", 32'(bus.commit), 32'd1);
    cyc();
    bus.dhit = 0; bus.dREN = 0;
    check("ld_done_dmemREN", 32'(bus.dmemREN), 32'd0);
    check("ld_done_pc", bus.pc, 32'h4);
    check("ld_done_imemREN", 32'(bus.imemREN), 32'd1);
    $display("load: pc=%h", bus.pc);

    // Store handshake
    bus.dWEN = 1; bus.ihit = 1; cyc(); bus.ihit = 0;
    check("st_dmemWEN", 32'(bus.dmemWEN), 32'd1);
    cyc(); cyc(); cyc();
    check("st_held", 32'(bus.dmemWEN), 32'd1);
    bus.dhit = 1; cyc(); bus.dhit = 0; bus.dWEN = 0;
    check("st_done_dmemWEN", 32'(bus.dmemWEN), 32'd0);
    check("st_done_pc", bus.pc, 32'h8);
    $display("store: pc=%h", bus.pc);

    // Spurious dhit in FETCH
    bus.dhit = 1; cyc(); cyc(); bus.dhit = 0;
    check("spurious_pc", bus.pc, 32'h8);
    check("spurious_dmemREN", 32'(bus.dmemREN), 32'd0);
    $display("spurious dhit: pc=%h", bus.pc);

    // Asynchronous reset in the middle of a store
    jr_to(32'h200);
    bus.dWEN = 1; bus.ihit = 1; cyc(); bus.ihit = 0;
    check("mid_data_dmemWEN", 32'(bus.dmemWEN), 32'd1);
    #1 nRST = 1'b0;
    #1;
    check("async_pc", bus.pc, 32'h0);
    check("async_dmemWEN", 32'(bus.dmemWEN), 32'd0);
    check("async_imemREN", 32'(bus.imemREN), 32'd1);
    bus.dWEN = 0;
    cyc();
    nRST = 1'b1;
    cyc();
    check("post_reset_imemREN", 32'(bus.imemREN), 32'd1);
    $display("async reset mid-DATA: pc=%h", bus.pc);

    // Halt is sticky until reset
    bus.ihit = 1; cyc();
    check("pre_halt_pc", bus.pc, 32'h4);
    bus.halt = 1; cyc();
    check("halt_halted", 32'(bus.halted), 32'd1);
    check("halt_imemREN", 32'(bus.imemREN), 32'd0);
    check("halt_pc", bus.pc, 32'h4);
    bus.halt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.ihit = i[0]; bus.dhit = !i[0]; bus.dREN = i[1];
      cyc();
    end
    bus.ihit = 0; bus.dhit = 0; bus.dREN = 0;
    check("halt_frozen_pc", bus.pc, 32'h4);
    check("halt_sticky", 32'(bus.halted), 32'd1);
    $display("halt: pc=%h halted=%0d", bus.pc, bus.halted);
    #1 nRST = 1'b0;
    #1;
    check("halt_reset_halted", 32'(bus.halted), 32'd0);
    check("halt_reset_pc", bus.pc, 32'h0);
    cyc();
    nRST = 1'b1;
    cyc(); cyc();
    $display("halt cleared by reset: pc=%h", bus.pc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_request_unit.md
Name: fetch_request_unit

Overview:
- Sits directly downstream of the control unit in the single-cycle datapath. It consumes the decoded branch, jump, memory-request and halt controls.
- Owns the PC register, next-PC selection and the memory-request handshake toward the cache/memory arbiter.
- Sequences each instruction through fetch, an optional data access, and the PC update.
- Gates the register-file write enable so each instruction commits exactly once.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction-memory access complete this cycle.
- dhit  in  1  data-memory access complete this cycle.
- PCSrc  in  1  instruction is a conditional branch.
- BNE  in  1  branch sense: 1 = branch on not-equal.
- zero  in  1  ALU zero flag.
- JumpSel  in  2  00 = sequential/branch, 01 = J/JAL target, 10 = JR register, 11 = reserved.
- imm  in  16  branch offset, word-granular.
- jaddr  in  26  instruction[25:0].
- jr_addr  in  32  rs register value.
- halt  in  1  decoded HALT.
- dREN  in  1  decoded load.
- dWEN  in  1  decoded store.
- pc  out  32  current PC, drives instruction address.
- pc_plus4  out  32  pc+4, used for the JAL link value.
- imemREN  out  1  instruction read request.
- dmemREN  out  1  data read request.
- dmemWEN  out  1  data write request.
- commit  out  1  one-cycle strobe; gates RegWEN and marks PC update.
- halted  out  1  sticky halt indication.

Behaviour:
- FSM states: FETCH, DATA, HALT. Reset state is FETCH.
- Reset (async, nRST=0):
  - state=FETCH, pc=PC_INIT.
  - dmemREN=dmemWEN=0, halted=0.
  - Applies immediately, including mid-DATA: any outstanding request drops in the same cycle.
- FETCH:
  - imemREN=1.
  - On ihit with halt=1: next state HALT. pc unchanged, commit=0.
  - On ihit with (dREN|dWEN)=1: next state DATA. Register dmemREN<=dREN and dmemWEN<=dWEN. pc unchanged, commit=0.
  - On ihit with no data access: commit=1, pc<=next_pc, stay in FETCH.
  - No ihit: hold all state.
  - dhit in FETCH is ignored.
- DATA:
  - imemREN=0. dmemREN/dmemWEN held stable until dhit.
  - On dhit: commit=1, pc<=next_pc, clear dmemREN/dmemWEN, next state FETCH.
  - ihit in DATA is ignored.
- HALT:
  - imemREN=dmemREN=dmemWEN=0, commit=0, halted=1, pc frozen.
  - Exited only by reset.
- dREN and dWEN both set: illegal decode. Both requests are issued as given; the bench must not drive it.
- commit is combinational from state and hit. It is high for exactly one cycle per non-halt instruction.
- next_pc arithmetic, all 32-bit, modulo 2^32:
  - pc_plus4 = pc + 4, wraps 32'hFFFF_FFFC to 0.
  - taken = PCSrc & (zero ^ BNE).
  - br_target = pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}).
  - JumpSel=00: taken ? br_target : pc_plus4.
  - JumpSel=01: {pc_plus4[31:28], jaddr, 2'b00}.
  - JumpSel=10: {jr_addr[31:2], 2'b00}. The low bits are forced so pc stays word-aligned.
  - JumpSel=11: pc_plus4.
- Control inputs are sampled only in the cycle commit=1. They must be stable through DATA because the instruction is held by pc.

Decomposition:
- Add to cpu_types_pkg:
  - fetch_state_t enum {FETCH, DATA, HALT}.
  - jumpsel_t constants JS_SEQ=2'b00, JS_J=2'b01, JS_JR=2'b10.
  - PC_STEP=32'd4.
- Natural sub-module: next_pc_logic, purely combinational; computes pc_plus4 and next_pc.
- The FSM and PC register stay in fetch_request_unit.
- Add a fetch_request_unit_if interface with fru and tb modports, matching existing interface style.

Test Plan:
- Reset: nRST=0 mid-DATA with dmemWEN=1 -> same cycle pc=0, dmemWEN=0, state FETCH. After release: imemREN=1.
- Sequential: pc=0x40, ihit=1, JumpSel=00, PCSrc=0 -> commit=1 for one cycle, next pc=0x44. With ihit=0, pc holds 0x44 and commit=0.
- Branch:
  - pc=0x100, PCSrc=1, BNE=0, zero=1, imm=16'hFFFE, ihit -> pc=0xFC.
  - Same with zero=0 -> pc=0x104.
  - BNE=1, zero=0 -> pc=0xFC.
- Jumps:
  - pc=0x1000_0000, JumpSel=01, jaddr=26'h0000040 -> pc=0x1000_0100.
  - JumpSel=10, jr_addr=0x2003 -> pc=0x2000.
  - pc=0xFFFF_FFFC sequential -> pc=0.
- Load/store handshake:
  - dREN=1, ihit -> dmemREN=1 next cycle, imemREN=0, pc unchanged.
  - 3 cycles no dhit -> request held.
  - dhit -> commit=1, dmemREN=0 next cycle, pc+4, back in FETCH.
  - Repeat with dWEN=1.
  - Spurious dhit in FETCH -> no effect.
- Halt: ihit with halt=1 -> halted=1, imemREN=0, pc frozen. 20 cycles of ihit/dhit toggling -> no change. nRST=0 -> halted=0, pc=PC_INIT.
